// File: rtl/full_adder.sv
// rtl/full_adder.sv - ripple-carry adder of 1-bit full-adder cells with combinational and registered results
// Optional simulation checker enabled by defining FULL_ADDER_CHECK_EN.
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_q,
  output logic             out_valid
);

  logic [WIDTH:0] chain;

  // Cells are evaluated in one process so sum and carry settle together.
  always_comb begin
    chain    = '0;
    sum      = '0;
    chain[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]     = a[i] ^ b[i] ^ chain[i];
      chain[i+1] = (a[i] & b[i]) | (chain[i] & (a[i] ^ b[i]));
    end
    carry = chain[WIDTH];
`ifdef FULL_ADDER_CHECK_EN
    if ({chain[WIDTH], sum} != ({1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin)))
      $error("full_adder comb: a=%0h b=%0h cin=%0b got %0h exp %0h",
             a, b, cin, {chain[WIDTH], sum}, {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin));
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q     <= '0;
      carry_q   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum_q   <= sum;
        carry_q <= carry;
      end
    end
  end

`ifdef FULL_ADDER_CHECK_EN
  logic [WIDTH:0]   ref_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;

  always_ff @(posedge clk) begin
    if (!rst && out_valid && ({carry_q, sum_q} != ref_q))
      $error("full_adder reg: a=%0h b=%0h cin=%0b got %0h exp %0h",
             a_q, b_q, cin_q, {carry_q, sum_q}, ref_q);
    if (!rst && in_valid) begin
      ref_q <= {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
      a_q   <= a;
      b_q   <= b;
      cin_q <= cin;
    end
  end
`endif

endmodule

// File: tb/tb_full_adder.sv
// tb/tb_full_adder.sv - directed self-checking bench for full_adder at WIDTH=1 and WIDTH=4
module tb_full_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       a, b, cin, in_valid;
  logic       sum, carry, sum_q, carry_q, out_valid;
  logic [3:0] a4, b4, sum4, sum4_q;
  logic       cin4, carry4, carry4_q, out_valid4;

  int checks = 0;
  int errors = 0;

  // Bit i of each word is the expected result for {a,b,cin} == i.
  logic [7:0] exp_sum   = 8'h96;
  logic [7:0] exp_carry = 8'hE8;
  logic [2:0] vec;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
    .sum(sum), .carry(carry), .sum_q(sum_q), .carry_q(carry_q), .out_valid(out_valid)
  );

  full_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(cin4), .in_valid(1'b0),
    .sum(sum4), .carry(carry4), .sum_q(sum4_q), .carry_q(carry4_q), .out_valid(out_valid4)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = 1'b0; b = 1'b0; cin = 1'b0;
    a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
    after_edge();
    after_edge();
    check("rst_sum_q", 8'(sum_q), 8'h0);
    check("rst_carry_q", 8'(carry_q), 8'h0);
    check("rst_out_valid", 8'(out_valid), 8'h0);

    // Exhaustive combinational sweep, 10 ns per vector
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vec = 3'(i);
      {a, b, cin} = vec;
      #10;
      check($sformatf("comb_sum_%0d", i), 8'(sum), 8'(exp_sum[i]));
      check($sformatf("comb_carry_%0d", i), 8'(carry), 8'(exp_carry[i]));
    end

    // Reset held for two edges with valid operands present
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; a = 1'b1; b = 1'b1; cin = 1'b1;
    for (int k = 0; k < 2; k++) begin
      after_edge();
      check("rsthold_sum_q", 8'(sum_q), 8'h0);
      check("rsthold_carry_q", 8'(carry_q), 8'h0);
      check("rsthold_out_valid", 8'(out_valid), 8'h0);
      check("rsthold_sum", 8'(sum), 8'h1);
      check("rsthold_carry", 8'(carry), 8'h1);
    end

    // Single-sample latency and hold
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b1; a = 1'b1; b = 1'b0; cin = 1'b1;
    after_edge();
    check("lat_sum_q", 8'(sum_q), 8'h0);
    check("lat_carry_q", 8'(carry_q), 8'h1);
    check("lat_out_valid", 8'(out_valid), 8'h1);
    in_valid = 1'b0; a = 1'b0; b = 1'b0; cin = 1'b0;
    after_edge();
    check("hold_out_valid", 8'(out_valid), 8'h0);
    check("hold_sum_q", 8'(sum_q), 8'h0);
    check("hold_carry_q", 8'(carry_q), 8'h1);

    // Streaming: one sample per cycle over all combinations
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vec = 3'(i);
      {a, b, cin} = vec;
      in_valid = 1'b1;
      after_edge();
      check($sformatf("strm_sum_q_%0d", i), 8'(sum_q), 8'(exp_sum[i]));
      check($sformatf("strm_carry_q_%0d", i), 8'(carry_q), 8'(exp_carry[i]));
      check($sformatf("strm_out_valid_%0d", i), 8'(out_valid), 8'h1);
    end

    // Reset coinciding with a valid sample discards it
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; a = 1'b1; b = 1'b1; cin = 1'b0;
    after_edge();
    check("midrst_out_valid", 8'(out_valid), 8'h0);
    check("midrst_sum_q", 8'(sum_q), 8'h0);
    check("midrst_carry_q", 8'(carry_q), 8'h0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;

    // WIDTH=4 wrap-around
    a4 = 4'hF; b4 = 4'h1; cin4 = 1'b0; #1;
    check("w4_f_1_sum", 8'(sum4), 8'h0);
    check("w4_f_1_carry", 8'(carry4), 8'h1);
    a4 = 4'h7; b4 = 4'h8; cin4 = 1'b1; #1;
    check("w4_7_8_sum", 8'(sum4), 8'h0);
    check("w4_7_8_carry", 8'(carry4), 8'h1);
    a4 = 4'h3; b4 = 4'h4; cin4 = 1'b0; #1;
    check("w4_3_4_sum", 8'(sum4), 8'h7);
    check("w4_3_4_carry", 8'(carry4), 8'h0);
    check("w4_out_valid", 8'(out_valid4), 8'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
